// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: stall FSM states, register address width
// and the forwarding-select encodings used by the EX-stage forwarding unit.
package cpu_pkg;

  localparam int REG_AW = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } stallState_t;

  localparam logic [1:0] FWD_MEM = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_RF  = 2'b11;

  // One ID source conflicts with the EX destination only when it is really read.
  function automatic logic srcHit(input logic rd, input logic [REG_AW-1:0] src,
                                  input logic [REG_AW-1:0] dst);
    return rd && (src == dst);
  endfunction

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by the ID
// instruction cannot be forwarded in time, so ID must wait one cycle.
module lu_detect #(
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rdReg1,
  input  logic [REG_AW-1:0] rdReg2,
  input  logic              use1,
  input  logic              use2,
  input  logic [REG_AW-1:0] wrReg,
  input  logic              memRd,
  output logic              luHit
);
  import cpu_pkg::*;

  // Register 0 is not special-cased: a hit on r0 stalls like any other.
  assign luHit = memRd && (srcHit(use1, rdReg1, wrReg) || srcHit(use2, rdReg2, wrReg));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use interlock, taken-branch flush,
// multi-cycle EX wait with timeout, and halt drain. Optional stall counter
// enabled by the STALL_PERF_EN macro.
//
// state   | meaning
// RUN     | normal issue; resolves branch/mc-start/load-use/halt by priority
// MC_WAIT | EX frozen waiting for mc_done, bounded by MC_MAX cycles
// DRAIN   | halt committed; letting EX/MEM/WB empty for DRAIN_CYC cycles
// HALTED  | core idle until resume
module pipe_stall_ctrl #(
  parameter int REG_AW    = cpu_pkg::REG_AW,
  parameter int MC_MAX    = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rdReg1_ID,
  input  logic [REG_AW-1:0] rdReg2_ID,
  input  logic              use1_ID,
  input  logic              use2_ID,
  input  logic [REG_AW-1:0] wrReg_EX,
  input  logic              memRd_EX,
  input  logic              branch_taken_EX,
  input  logic              mc_start_EX,
  input  logic              mc_done,
  input  logic              halt_ID,
  input  logic              resume,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic              halted,
  output logic              mc_timeout
`ifdef STALL_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       stall_cycles
`endif
);
  import cpu_pkg::*;

  localparam int CNT_MAX = (MC_MAX > DRAIN_CYC) ? MC_MAX : DRAIN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MC_LAST    = CNT_W'(MC_MAX);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  stallState_t      stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             timeoutQ, timeoutD;
  logic             luHit;

  lu_detect #(.REG_AW(REG_AW)) uLuDetect (
    .rdReg1 (rdReg1_ID),
    .rdReg2 (rdReg2_ID),
    .use1   (use1_ID),
    .use2   (use2_ID),
    .wrReg  (wrReg_EX),
    .memRd  (memRd_EX),
    .luHit  (luHit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ   <= RUN;
      cntQ     <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      timeoutQ <= timeoutD;
    end
  end

  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    timeoutD    = timeoutQ;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    halted      = 1'b0;

    unique case (stateQ)
      RUN: begin
        // Branch squashes the younger load-use victim and any halt in ID.
        if (branch_taken_EX) begin
          pc_we       = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (mc_start_EX) begin
          ex_hold = 1'b1;
          stateD  = MC_WAIT;
          cntD    = CNT_ONE;
        end else if (luHit) begin
          idex_bubble = 1'b1;
        end else if (halt_ID) begin
          ifid_flush = 1'b1;
          stateD     = DRAIN;
          cntD       = '0;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end

      MC_WAIT: begin
        if (mc_done) begin
          stateD = RUN;
        end else begin
          ex_hold = 1'b1;
          if (cntQ >= MC_LAST) begin
            timeoutD = 1'b1;
            stateD   = RUN;
          end else begin
            cntD = cntQ + CNT_ONE;
          end
        end
      end

      DRAIN: begin
        idex_bubble = 1'b1;
        if (cntQ >= DRAIN_LAST) begin
          stateD = HALTED;
        end else begin
          cntD = cntQ + CNT_ONE;
        end
      end

      HALTED: begin
        halted      = 1'b1;
        idex_bubble = 1'b1;
        if (resume) begin
          stateD = RUN;
        end
      end

      default: begin
        stateD = RUN;
      end
    endcase

    // While reset is held the pipe front end is frozen and flushed.
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      ex_hold     = 1'b0;
      halted      = 1'b0;
    end
  end

  assign mc_timeout = timeoutQ;

`ifdef STALL_PERF_EN
  logic [15:0] stallQ;

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      stallQ <= '0;
    end else if (!pc_we && (stateQ != HALTED) && (stallQ != 16'hFFFF)) begin
      stallQ <= stallQ + 16'd1;
    end
  end

  assign stall_cycles = stallQ;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked cycle-by-cycle against a model.
module tb_pipe_stall_ctrl;

  localparam int MC_MAX    = 32;
  localparam int DRAIN_CYC = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rdReg1_ID, rdReg2_ID, wrReg_EX;
  logic       use1_ID, use2_ID, memRd_EX, branch_taken_EX;
  logic       mc_start_EX, mc_done, halt_ID, resume;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, ex_hold, halted, mc_timeout;
`ifdef STALL_PERF_EN
  logic        perf_clr;
  logic [15:0] stall_cycles;
`endif

  int nChecks = 0;
  int nFail   = 0;

  // Model state: waiting count, drain cycles left, idle flag, sticky error.
  bit mHalted, mInMc, mTmo, mLu;
  int mElapsed, mDrainLeft, mStall;
  logic ePc, eIfid, eFlush, eBubble, eHold, eHalted;

  int holdCnt, drainCnt, doneRate;
  bit seenHalt;

  pipe_stall_ctrl #(.REG_AW(4), .MC_MAX(MC_MAX), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdReg1_ID       (rdReg1_ID),
    .rdReg2_ID       (rdReg2_ID),
    .use1_ID         (use1_ID),
    .use2_ID         (use2_ID),
    .wrReg_EX        (wrReg_EX),
    .memRd_EX        (memRd_EX),
    .branch_taken_EX (branch_taken_EX),
    .mc_start_EX     (mc_start_EX),
    .mc_done         (mc_done),
    .halt_ID         (halt_ID),
    .resume          (resume),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .ex_hold         (ex_hold),
    .halted          (halted),
    .mc_timeout      (mc_timeout)
`ifdef STALL_PERF_EN
    ,
    .perf_clr        (perf_clr),
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic expv);
    nChecks++;
    if (got !== expv) begin
      nFail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, expv, $time);
    end
  endtask

  task automatic chkN(input string name, input int got, input int expv);
    nChecks++;
    if (got !== expv) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  // What the outputs must be this cycle, from the model state and current inputs.
  task automatic calcExp();
    mLu = memRd_EX && ((use1_ID && rdReg1_ID == wrReg_EX) || (use2_ID && rdReg2_ID == wrReg_EX));
    {ePc, eIfid, eFlush, eBubble, eHold, eHalted} = 6'b0;
    if (!rst_n) begin
      eFlush = 1; eBubble = 1;
    end else if (mHalted) begin
      eHalted = 1; eBubble = 1;
    end else if (mDrainLeft > 0) begin
      eBubble = 1;
    end else if (mInMc) begin
      eHold = !mc_done;
    end else if (branch_taken_EX) begin
      ePc = 1; eFlush = 1; eBubble = 1;
    end else if (mc_start_EX) begin
      eHold = 1;
    end else if (mLu) begin
      eBubble = 1;
    end else if (halt_ID) begin
      eFlush = 1;
    end else begin
      ePc = 1; eIfid = 1;
    end
  endtask

  task automatic sampleCheck();
    @(negedge clk);
    calcExp();
    chk1("pc_we", pc_we, ePc);
    chk1("ifid_we", ifid_we, eIfid);
    chk1("ifid_flush", ifid_flush, eFlush);
    chk1("idex_bubble", idex_bubble, eBubble);
    chk1("ex_hold", ex_hold, eHold);
    chk1("halted", halted, eHalted);
    chk1("mc_timeout", mc_timeout, mTmo);
`ifdef STALL_PERF_EN
    chkN("stall_cycles", int'(stall_cycles), mStall);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    calcExp();
`ifdef STALL_PERF_EN
    if (!rst_n || perf_clr) mStall = 0;
    else if (!ePc && !mHalted && mStall < 65535) mStall++;
`endif
    if (!rst_n) begin
      mHalted = 0; mInMc = 0; mTmo = 0; mElapsed = 0; mDrainLeft = 0;
    end else if (mHalted) begin
      if (resume) mHalted = 0;
    end else if (mDrainLeft > 0) begin
      mDrainLeft--;
      if (mDrainLeft == 0) mHalted = 1;
    end else if (mInMc) begin
      if (mc_done) mInMc = 0;
      else if (mElapsed == MC_MAX) begin mTmo = 1; mInMc = 0; end
      else mElapsed++;
    end else if (!branch_taken_EX) begin
      if (mc_start_EX) begin mInMc = 1; mElapsed = 1; end
      else if (!mLu && halt_ID) mDrainLeft = DRAIN_CYC;
    end
    #1;
  endtask

  task automatic cyc();
    sampleCheck();
    tick();
  endtask

  task automatic setIdle();
    rst_n = 1; rdReg1_ID = 0; rdReg2_ID = 0; wrReg_EX = 0;
    use1_ID = 0; use2_ID = 0; memRd_EX = 0; branch_taken_EX = 0;
    mc_start_EX = 0; mc_done = 0; halt_ID = 0; resume = 0;
`ifdef STALL_PERF_EN
    perf_clr = 0;
`endif
  endtask

  initial begin
    mHalted = 0; mInMc = 0; mTmo = 0; mElapsed = 0; mDrainLeft = 0; mStall = 0;
    setIdle();
    rst_n = 0;

    // Reset values
    sampleCheck();
    chk1("rst_pc_we", pc_we, 1'b0);
    chk1("rst_ifid_we", ifid_we, 1'b0);
    chk1("rst_flush", ifid_flush, 1'b1);
    chk1("rst_bubble", idex_bubble, 1'b1);
    chk1("rst_hold", ex_hold, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    tick();
    cyc();
    setIdle();
    sampleCheck();
    chk1("run_pc_we", pc_we, 1'b1);
    tick();

    // Load-use: one stall cycle, then issue resumes
    memRd_EX = 1; wrReg_EX = 5; rdReg1_ID = 5; use1_ID = 1;
    sampleCheck();
    chk1("lu_pc_we", pc_we, 1'b0);
    chk1("lu_ifid_we", ifid_we, 1'b0);
    chk1("lu_bubble", idex_bubble, 1'b1);
    tick();
    memRd_EX = 0;
    sampleCheck();
    chk1("lu_after_pc_we", pc_we, 1'b1);
    tick();

    // Same registers, but src not actually read: no stall
    memRd_EX = 1; use1_ID = 0; rdReg2_ID = 5; use2_ID = 0;
    sampleCheck();
    chk1("lu_unused_pc_we", pc_we, 1'b1);
    tick();

    // Branch beats load-use
    setIdle();
    memRd_EX = 1; wrReg_EX = 7; rdReg2_ID = 7; use2_ID = 1; branch_taken_EX = 1;
    sampleCheck();
    chk1("br_pc_we", pc_we, 1'b1);
    chk1("br_flush", ifid_flush, 1'b1);
    chk1("br_bubble", idex_bubble, 1'b1);
    tick();
    setIdle();
    sampleCheck();
    chk1("br_no_extra_stall", pc_we, 1'b1);
    tick();

    // Multi-cycle op, done arrives 7 cycles after start
    mc_start_EX = 1;
    holdCnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) mc_start_EX = 0;
      mc_done = (k == 7);
      sampleCheck();
      if (ex_hold) holdCnt++;
      tick();
    end
    chkN("mc_hold_len", holdCnt, 7);
    setIdle();
    sampleCheck();
    chk1("mc_resume_pc_we", pc_we, 1'b1);
    tick();

    // mc_done coincident with mc_start is ignored
    mc_start_EX = 1; mc_done = 1;
    cyc();
    mc_start_EX = 0; mc_done = 0;
    sampleCheck();
    chk1("mc_start_done_ignored", ex_hold, 1'b1);
    tick();
    mc_done = 1;
    cyc();
    setIdle();

    // Timeout: no done at all
    mc_start_EX = 1;
    for (int k = 0; k <= 33; k++) begin
      if (k == 1) mc_start_EX = 0;
      sampleCheck();
      if (k == 32) begin
        chk1("tmo_not_yet", mc_timeout, 1'b0);
        chk1("tmo_hold_last", ex_hold, 1'b1);
      end
      if (k == 33) begin
        chk1("tmo_set", mc_timeout, 1'b1);
        chk1("tmo_run_pc_we", pc_we, 1'b1);
      end
      tick();
    end
    repeat (4) cyc();
    sampleCheck();
    chk1("tmo_sticky", mc_timeout, 1'b1);
    tick();

    // Halt, drain (branch ignored), halted, resume
    halt_ID = 1;
    sampleCheck();
    chk1("halt_pc_we", pc_we, 1'b0);
    chk1("halt_flush", ifid_flush, 1'b1);
    tick();
    halt_ID = 0;
    drainCnt = 0; seenHalt = 0;
    for (int k = 0; k < 8; k++) begin
      branch_taken_EX = (k == 0);
      sampleCheck();
      if (k == 0) chk1("drain_ignores_branch", pc_we, 1'b0);
      if (halted) seenHalt = 1;
      else if (!seenHalt) drainCnt++;
      tick();
    end
    chkN("drain_len", drainCnt, 3);
    setIdle();
    sampleCheck();
    chk1("halted_idle", halted, 1'b1);
    tick();
    resume = 1;
    sampleCheck();
    chk1("halted_during_resume", halted, 1'b1);
    tick();
    resume = 0;
    sampleCheck();
    chk1("resumed_halted", halted, 1'b0);
    chk1("resumed_pc_we", pc_we, 1'b1);
    tick();

    // Reset in the middle of a multi-cycle wait clears timeout too
    mc_start_EX = 1;
    cyc();
    mc_start_EX = 0;
    repeat (3) cyc();
    rst_n = 0;
    sampleCheck();
    chk1("rst_mc_hold", ex_hold, 1'b0);
    chk1("rst_mc_flush", ifid_flush, 1'b1);
    tick();
    rst_n = 1;
    sampleCheck();
    chk1("post_rst_hold", ex_hold, 1'b0);
    chk1("post_rst_tmo", mc_timeout, 1'b0);
    chk1("post_rst_pc_we", pc_we, 1'b1);
    tick();

`ifdef STALL_PERF_EN
    memRd_EX = 1; wrReg_EX = 3; rdReg1_ID = 3; use1_ID = 1;
    repeat (3) cyc();
    setIdle();
    perf_clr = 1;
    cyc();
    perf_clr = 0;
    sampleCheck();
    chkN("perf_clr_zero", int'(stall_cycles), 0);
    tick();
`endif

    // Randomized traffic
    doneRate = 12;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) doneRate = (n % 1000 == 0) ? 60 : 8;
      rst_n           = ($urandom_range(0, 199) != 0);
      memRd_EX        = ($urandom_range(0, 2) == 0);
      wrReg_EX        = 4'($urandom_range(0, 3));
      rdReg1_ID       = 4'($urandom_range(0, 3));
      rdReg2_ID       = 4'($urandom_range(0, 3));
      use1_ID         = 1'($urandom_range(0, 1));
      use2_ID         = 1'($urandom_range(0, 1));
      branch_taken_EX = ($urandom_range(0, 9) == 0);
      mc_start_EX     = ($urandom_range(0, 14) == 0);
      mc_done         = ($urandom_range(0, doneRate - 1) == 0);
      halt_ID         = ($urandom_range(0, 29) == 0);
      resume          = ($urandom_range(0, 5) == 0);
`ifdef STALL_PERF_EN
      perf_clr        = ($urandom_range(0, 19) == 0);
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
